mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: RAM access latency in cycles, legal range 1..15.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 start_i  input  1  enable; 0 blocks new grants.
REQ-005 if_req_i  input  1  fetch-stage read request, held until if_ack_o.
REQ-006 if_addr_i  input  32  fetch byte address.
REQ-007 if_data_o  output  32  fetched word (registered).
REQ-008 if_ack_o  output  1  one-cycle fetch completion pulse.
REQ-009 mem_req_i  input  1  MEM-stage request, held until mem_ack_o.
REQ-010 mem_we_i  input  1  1 = write, 0 = read.
REQ-011 mem_addr_i  input  32  MEM byte address.
REQ-012 mem_wdata_i  input  32  write data.
REQ-013 mem_rdata_o  output  32  read word (registered).
REQ-014 mem_ack_o  output  1  one-cycle MEM completion pulse.
REQ-015 ram_en_o, ram_we_o  output  1 each  shared RAM port strobes.
REQ-016 ram_addr_o, ram_wdata_o  output  32 each  shared RAM port address/data.
REQ-017 ram_rdata_i  input  32  RAM read data, valid on the last access cycle.
REQ-018 stall_o  output  1  pipeline stall request.

Function
REQ-019 FSM states IDLE, IF_ACC, MEM_ACC, RESP; exactly one active.
REQ-020 IDLE, start_i=1: grant MEM if mem_req_i, else IF if if_req_i; exception: last grant MEM and if_req_i=1 -> grant IF (no starvation).
REQ-021 Grant edge: latch address/wdata/we into port registers, load 4-bit counter with MEM_LAT-1, enter IF_ACC or MEM_ACC.
REQ-022 xx_ACC: ram_en_o=1, ram_addr_o/ram_wdata_o/ram_we_o stable (ram_we_o=0 in IF_ACC); counter decrements each edge.
REQ-023 Edge with counter==0 in xx_ACC: capture ram_rdata_i into if_data_o (IF) or mem_rdata_o (MEM read only; MEM write leaves it unchanged), go RESP.
REQ-024 RESP lasts exactly one cycle: matching ack high, ram_en_o=0, no grant; next state IDLE.
REQ-025 Access cost MEM_LAT+2 cycles per request: grant edge k, ack during cycle after edge k+MEM_LAT, next grant earliest at edge k+MEM_LAT+2.
REQ-026 stall_o = start_i & ((if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o)), combinational.
REQ-027 start_i dropping mid-access: access and RESP complete normally; no further grants.
REQ-028 Request withdrawn mid-access: access completes, ack still pulsed, data still captured.
REQ-029 Acks never both high in one cycle; ram_en_o never high in IDLE or RESP.

Reset
REQ-030 rst_i=1 immediately forces IDLE, counter 0, last-grant flag to IF, all outputs 0 (data registers 0), independent of clk_i.
REQ-031 Reset during an access aborts it; no ack for it after release.

Verification (MEM_LAT=2)
REQ-032 Reset mid-MEM_ACC -> ram_en_o drops same timestep; all outputs 0; no mem_ack_o after release.
REQ-033 IF read 0x04 granted edge 0, ram_rdata_i=0x8C010000 -> ram_en_o high cycles 1-2, if_ack_o high cycle 3 only, if_data_o=0x8C010000, stall_o high cycles 0-2, low cycle 3.
REQ-034 if_req_i and mem_req_i together at edge 0 -> MEM granted edge 0 (ack cycle 3), IF granted edge 4 (ack cycle 7).
REQ-035 mem_req_i continuously re-asserted with if_req_i held -> grants alternate MEM, IF, MEM.
REQ-036 MEM write 0x10 data 5 -> ram_we_o=1, ram_addr_o=0x10, ram_wdata_o=5 for 2 cycles; mem_ack_o pulses; mem_rdata_o unchanged.
REQ-037 start_i=0 with if_req_i=1 -> no grant, stall_o=0; start_i falling mid-access -> ack still delivered, then idle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the fetch stage (IF) and
// the MEM stage. A four-state FSM grants one requester at a time, holds the
// RAM strobes for MEM_LAT cycles, captures read data on the last access
// cycle and then spends one RESP cycle pulsing the matching ack.
//
// Ports
//   clk_i, rst_i                  clock, async active-high reset
//   start_i                       enable; low blocks new grants
//   if_req_i, if_addr_i           fetch read request and byte address
//   if_data_o, if_ack_o           fetched word (registered), completion pulse
//   mem_req_i, mem_we_i           MEM-stage request, 1 = write
//   mem_addr_i, mem_wdata_i       MEM-stage address and write data
//   mem_rdata_o, mem_ack_o        read word (registered), completion pulse
//   ram_en_o, ram_we_o            shared RAM strobes
//   ram_addr_o, ram_wdata_o       shared RAM address and write data
//   ram_rdata_i                   RAM read data, valid on last access cycle
//   stall_o                       pipeline stall request (combinational)
//
// state   | meaning
// IDLE    | waiting for a request while start_i is high
// IF_ACC  | RAM access on behalf of the fetch stage
// MEM_ACC | RAM access on behalf of the MEM stage
// RESP    | one cycle: ack pulse, RAM idle, no grant
module mem_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        ram_en_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  output logic        stall_o
);

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_ACC  = 2'd1,
    S_MEM_ACC = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_last_mem;
  logic        r_sel_mem;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_if_data;
  logic [31:0] r_mem_rdata;
  logic        w_grant_if;
  logic        w_grant_mem;
  logic        w_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          // MEM normally wins, but after a MEM grant a waiting fetch goes
          // first so back-to-back MEM traffic cannot starve IF.
          if (mem_req_i && !(r_last_mem && if_req_i)) begin
            w_grant_mem = 1'b1;
            w_state_nxt = S_MEM_ACC;
          end else if (if_req_i) begin
            w_grant_if  = 1'b1;
            w_state_nxt = S_IF_ACC;
          end
        end
      end
      S_IF_ACC, S_MEM_ACC: begin
        if (r_cnt == 4'd0) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt       <= 4'd0;
      r_last_mem  <= 1'b0;
      r_sel_mem   <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_if_data   <= 32'd0;
      r_mem_rdata <= 32'd0;
    end else begin
      if (w_grant_mem) begin
        r_cnt      <= LAT_LOAD;
        r_last_mem <= 1'b1;
        r_sel_mem  <= 1'b1;
        r_we       <= mem_we_i;
        r_addr     <= mem_addr_i;
        r_wdata    <= mem_wdata_i;
      end else if (w_grant_if) begin
        r_cnt      <= LAT_LOAD;
        r_last_mem <= 1'b0;
        r_sel_mem  <= 1'b0;
        r_we       <= 1'b0;
        r_addr     <= if_addr_i;
        r_wdata    <= 32'd0;
      end else if (w_done) begin
        if (!r_sel_mem)  r_if_data   <= ram_rdata_i;
        else if (!r_we)  r_mem_rdata <= ram_rdata_i;
      end else if (r_state == S_IF_ACC || r_state == S_MEM_ACC) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign ram_en_o    = (r_state == S_IF_ACC) || (r_state == S_MEM_ACC);
  assign ram_we_o    = (r_state == S_MEM_ACC) && r_we;
  assign ram_addr_o  = r_addr;
  assign ram_wdata_o = r_wdata;
  assign if_data_o   = r_if_data;
  assign mem_rdata_o = r_mem_rdata;
  assign if_ack_o    = (r_state == S_RESP) && !r_sel_mem;
  assign mem_ack_o   = (r_state == S_RESP) && r_sel_mem;
  assign stall_o     = start_i && ((if_req_i && !if_ack_o) || (mem_req_i && !mem_ack_o));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT = 2): a cycle table for the basic
// IF read, IF/MEM contention and MEM write, then hand-written sequences for
// alternation, start_i gating and reset mid-access.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = 32'd0;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = 32'd0;
  logic [31:0] mem_wdata_i = 32'd0;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        ram_en_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i = 32'd0;
  logic        stall_o;

  mem_arbiter #(.MEM_LAT(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [31:0] C = 32'h8C010000;
  localparam logic [31:0] M = 32'h11112222;
  localparam logic [31:0] I = 32'h33334444;
  localparam logic [31:0] D = 32'hDEADBEEF;

  // ctl = {start, if_req, mem_req, mem_we}; exo = {ram_en, ram_we, if_ack, mem_ack, stall}
  // ea is checked only when ram_en is expected, ewd only when ram_we is expected.
  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] ifa, ma, wd, rd;
    logic [4:0]  exo;
    logic [31:0] ea, ewd, eifd, emd;
  } vec_t;

  vec_t tbl[19];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick_drive();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int kind[3];
    int cyc[3];
    int n;
    int both;
    int bad;
    int got_ack;
    logic [255:0] g, e;

    // IF read 0x04
    tbl[0]  = '{4'b1100, 32'h4, 32'h0, 32'h0, C, 5'b00001, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[1]  = '{4'b1100, 32'h4, 32'h0, 32'h0, C, 5'b10001, 32'h4, 32'h0, 32'h0, 32'h0};
    tbl[2]  = '{4'b1100, 32'h4, 32'h0, 32'h0, C, 5'b10001, 32'h4, 32'h0, 32'h0, 32'h0};
    tbl[3]  = '{4'b1100, 32'h4, 32'h0, 32'h0, C, 5'b00100, 32'h0, 32'h0, C, 32'h0};
    tbl[4]  = '{4'b1000, 32'h4, 32'h0, 32'h0, C, 5'b00000, 32'h0, 32'h0, C, 32'h0};
    // IF and MEM together: MEM read first, IF at edge 4
    tbl[5]  = '{4'b1110, 32'h100, 32'h200, 32'h0, M, 5'b00001, 32'h0, 32'h0, C, 32'h0};
    tbl[6]  = '{4'b1110, 32'h100, 32'h200, 32'h0, M, 5'b10001, 32'h200, 32'h0, C, 32'h0};
    tbl[7]  = '{4'b1110, 32'h100, 32'h200, 32'h0, M, 5'b10001, 32'h200, 32'h0, C, 32'h0};
    tbl[8]  = '{4'b1110, 32'h100, 32'h200, 32'h0, M, 5'b00011, 32'h0, 32'h0, C, M};
    tbl[9]  = '{4'b1100, 32'h100, 32'h200, 32'h0, I, 5'b00001, 32'h0, 32'h0, C, M};
    tbl[10] = '{4'b1100, 32'h100, 32'h200, 32'h0, I, 5'b10001, 32'h100, 32'h0, C, M};
    tbl[11] = '{4'b1100, 32'h100, 32'h200, 32'h0, I, 5'b10001, 32'h100, 32'h0, C, M};
    tbl[12] = '{4'b1100, 32'h100, 32'h200, 32'h0, I, 5'b00100, 32'h0, 32'h0, I, M};
    tbl[13] = '{4'b1000, 32'h100, 32'h200, 32'h0, I, 5'b00000, 32'h0, 32'h0, I, M};
    // MEM write 0x10 <- 5; mem_rdata_o must keep M
    tbl[14] = '{4'b1011, 32'h0, 32'h10, 32'h5, D, 5'b00001, 32'h0, 32'h0, I, M};
    tbl[15] = '{4'b1011, 32'h0, 32'h10, 32'h5, D, 5'b11001, 32'h10, 32'h5, I, M};
    tbl[16] = '{4'b1011, 32'h0, 32'h10, 32'h5, D, 5'b11001, 32'h10, 32'h5, I, M};
    tbl[17] = '{4'b1011, 32'h0, 32'h10, 32'h5, D, 5'b00010, 32'h0, 32'h0, I, M};
    tbl[18] = '{4'b1000, 32'h0, 32'h10, 32'h5, D, 5'b00000, 32'h0, 32'h0, I, M};

    // reset state
    #12;
    chk("reset_outputs",
        {ram_en_o, ram_we_o, if_ack_o, mem_ack_o, stall_o, ram_addr_o, ram_wdata_o, if_data_o, mem_rdata_o},
        '0);
    tick_drive();
    rst_i = 1'b0;

    for (int i = 0; i < 19; i++) begin
      tick_drive();
      {start_i, if_req_i, mem_req_i, mem_we_i} = tbl[i].ctl;
      if_addr_i   = tbl[i].ifa;
      mem_addr_i  = tbl[i].ma;
      mem_wdata_i = tbl[i].wd;
      ram_rdata_i = tbl[i].rd;
      @(negedge clk_i);
      g = {ram_en_o, ram_we_o, if_ack_o, mem_ack_o, stall_o,
           (tbl[i].exo[4] ? ram_addr_o : 32'h0), (tbl[i].exo[3] ? ram_wdata_o : 32'h0),
           if_data_o, mem_rdata_o};
      e = {tbl[i].exo, tbl[i].ea, tbl[i].ewd, tbl[i].eifd, tbl[i].emd};
      chk($sformatf("row%0d", i), g, e);
    end

    // Alternation after reset (last grant = IF): MEM, IF, MEM, 4 cycles apart
    tick_drive();
    rst_i = 1'b1;
    tick_drive();
    rst_i = 1'b0;
    start_i = 1'b1; if_req_i = 1'b1; mem_req_i = 1'b1; mem_we_i = 1'b0;
    ram_rdata_i = 32'h12345678;
    n = 0; both = 0;
    for (int k = 0; k < 3; k++) begin kind[k] = -1; cyc[k] = -100; end
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk_i);
      if (if_ack_o && mem_ack_o) both++;
      if (mem_ack_o)     begin kind[n] = 1; cyc[n] = c; n++; end
      else if (if_ack_o) begin kind[n] = 0; cyc[n] = c; n++; end
    end
    chk("alt_ack_count", 256'(n), 256'(3));
    chk("alt_order", {224'd0, kind[0], kind[1]}, {224'd0, 32'd1, 32'd0});
    chk("alt_order_third", 256'(kind[2]), 256'(1));
    chk("alt_spacing", {cyc[1] - cyc[0], cyc[2] - cyc[1]}, {32'd4, 32'd4});
    chk("alt_both_acks", 256'(both), 256'(0));
    chk("alt_mem_rdata", 256'(mem_rdata_o), 256'(32'h12345678));

    // start_i low blocks grants and stall
    tick_drive();
    start_i = 1'b0; if_req_i = 1'b1; mem_req_i = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (ram_en_o || stall_o || if_ack_o || mem_ack_o) bad++;
    end
    chk("start_low_no_grant", 256'(bad), 256'(0));

    // start_i falls right after the grant edge: access still completes
    tick_drive();
    start_i = 1'b1; if_req_i = 1'b1; ram_rdata_i = 32'h55AA55AA;
    tick_drive();
    start_i = 1'b0;
    got_ack = 0;
    for (int c = 0; c < 10 && got_ack == 0; c++) begin
      @(negedge clk_i);
      if (if_ack_o) got_ack = 1;
    end
    chk("start_fall_ack", 256'(got_ack), 256'(1));
    chk("start_fall_data", 256'(if_data_o), 256'(32'h55AA55AA));
    tick_drive();
    if_req_i = 1'b0; mem_req_i = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (ram_en_o || if_ack_o || mem_ack_o) bad++;
    end
    chk("start_fall_then_idle", 256'(bad), 256'(0));
    mem_req_i = 1'b0;

    // Reset mid MEM_ACC
    tick_drive();
    start_i = 1'b1; mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h40;
    tick_drive();
    #1;
    chk("pre_reset_en", 256'(ram_en_o), 256'(1));
    rst_i = 1'b1;
    #1;
    chk("reset_mid_access",
        {ram_en_o, ram_we_o, if_ack_o, mem_ack_o, ram_addr_o, ram_wdata_o, if_data_o, mem_rdata_o},
        '0);
    mem_req_i = 1'b0;
    tick_drive();
    rst_i = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (mem_ack_o || ram_en_o) bad++;
    end
    chk("no_ack_after_reset", 256'(bad), 256'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
